// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared types and constants for the stepper sequence controller.
//   state_e       : controller state (IDLE, RUN)
//   PHASE_IDX_W   : width of the phase-table index
//   STEP_HALF/FULL: index increment per step in half-/full-step mode
//   PHASE_TABLE   : 8-entry coil pattern table, entry 0 = 4'b1000
//   phase_pattern : table lookup helper
// -----------------------------------------------------------------------------
package stepper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PHASE_IDX_W = 3;

  localparam logic [PHASE_IDX_W-1:0] STEP_HALF = 3'd1;
  localparam logic [PHASE_IDX_W-1:0] STEP_FULL = 3'd2;

  // Packed so that PHASE_TABLE[i] is entry i; listed from entry 7 down to 0.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  function automatic logic [3:0] phase_pattern(input logic [PHASE_IDX_W-1:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// stepper_seq_ctrl_if
// Command/status and coil-pin bundle of the stepper sequence controller.
//   master : motion controller side (drives commands, reads status and coils)
//   slave  : stepper_seq_ctrl side
// Command : motor_enable, start, steps, dir, half_step, period, abort
// Status  : busy, done, steps_left, position
// Pins    : coil[3:0], coil_en
// -----------------------------------------------------------------------------
interface stepper_seq_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
);
  logic             motor_enable;
  logic             start;
  logic [CNT_W-1:0] steps;
  logic             dir;
  logic             half_step;
  logic [DIV_W-1:0] period;
  logic             abort;
  logic [3:0]       coil;
  logic             coil_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;
  logic [POS_W-1:0] position;

  modport master (
    output motor_enable, start, steps, dir, half_step, period, abort,
    input  coil, coil_en, busy, done, steps_left, position
  );

  modport slave (
    input  motor_enable, start, steps, dir, half_step, period, abort,
    output coil, coil_en, busy, done, steps_left, position
  );
endinterface

// File: rtl/stepper_seq_ctrl_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Step-rate divider. load clears the count and latches max(period,1); while en
// is high the count runs 0..P-1 and tick pulses combinationally on the cycle
// whose clock edge completes a period. With en low the count is frozen.
// Ports: clk, reset (async, active-high), load, period[DIV_W], en, tick.
// -----------------------------------------------------------------------------
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;

  assign tick = en && !load && (cnt_q == per_q - DIV_W'(1));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (load) begin
      cnt_d = '0;
      per_d = (period == '0) ? DIV_W'(1) : period;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      per_q <= DIV_W'(1);
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_seq_ctrl
// 4-coil stepper sequencer: accepts a move (steps, dir, half/full, period),
// steps through the 8-entry phase table at one step per period, tracks
// remaining steps and a signed position, and reports busy/done.
// Ports: clk, reset (async, active-high), bus (stepper_seq_ctrl_if.slave).
// All outputs are registered.
// Build option: STEPPER_HOLD_EN -- when defined, IDLE with motor_enable=1
// keeps the last pattern energised (holding torque) once a step has been made.
// -----------------------------------------------------------------------------
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  stepper_seq_ctrl_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [PHASE_IDX_W-1:0] idx_q, idx_d;
  logic                   dir_q, dir_d;
  logic                   half_q, half_d;
  logic [3:0]             coil_q, coil_d;
  logic                   coil_en_q, coil_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       steps_left_q, steps_left_d;
  logic [POS_W-1:0]       position_q, position_d;
`ifdef STEPPER_HOLD_EN
  logic                   hold_ok_q, hold_ok_d;
`endif

  logic                   timer_load;
  logic                   timer_en;
  logic                   tick;
  logic [PHASE_IDX_W-1:0] step_size;
  logic [PHASE_IDX_W-1:0] idx_next;
  logic                   energise;

  assign timer_load = (state_q == IDLE) && bus.start && (bus.steps != '0);
  assign timer_en   = (state_q == RUN) && bus.motor_enable;

  step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .period (bus.period),
    .en     (timer_en),
    .tick   (tick)
  );

  // 3-bit arithmetic gives the modulo-8 wrap for free.
  assign step_size = half_q ? STEP_HALF : STEP_FULL;
  assign idx_next  = dir_q ? (idx_q - step_size) : (idx_q + step_size);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    half_d       = half_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    steps_left_d = steps_left_q;
    position_d   = position_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.steps != '0) begin
            state_d      = RUN;
            busy_d       = 1'b1;
            steps_left_d = bus.steps;
            dir_d        = bus.dir;
            half_d       = bus.half_step;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          idx_d        = idx_next;
          steps_left_d = steps_left_q - CNT_W'(1);
          position_d   = dir_q ? (position_q - POS_W'(1)) : (position_q + POS_W'(1));
          if (steps_left_q == CNT_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        // A coincident step is still applied above; only the move ends here.
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The step edge always shows the new pattern, even when it ends the move.
`ifdef STEPPER_HOLD_EN
    hold_ok_d = hold_ok_q || tick;
    energise  = bus.motor_enable && ((state_d == RUN) || tick || hold_ok_d);
`else
    energise  = bus.motor_enable && ((state_d == RUN) || tick);
`endif
    coil_d    = energise ? phase_pattern(idx_d) : 4'b0000;
    coil_en_d = energise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      coil_q       <= '0;
      coil_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
      position_q   <= '0;
`ifdef STEPPER_HOLD_EN
      hold_ok_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      coil_q       <= coil_d;
      coil_en_q    <= coil_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      steps_left_q <= steps_left_d;
      position_q   <= position_d;
`ifdef STEPPER_HOLD_EN
      hold_ok_q    <= hold_ok_d;
`endif
    end
  end

  assign bus.coil       = coil_q;
  assign bus.coil_en    = coil_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_left = steps_left_q;
  assign bus.position   = position_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_seq_ctrl
// Directed bench for stepper_seq_ctrl (default parameters). Expected values
// are hand-derived from the phase table; idle-coil expectations follow the
// STEPPER_HOLD_EN build option.
// -----------------------------------------------------------------------------
module tb_stepper_seq_ctrl;

  localparam int DIV_W = 16;
  localparam int CNT_W = 16;
  localparam int POS_W = 24;

`ifdef STEPPER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [3:0] tbl [8];

  stepper_seq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

  stepper_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [POS_W-1:0] pos(input int v);
    return v[POS_W-1:0];
  endfunction

  function automatic logic [3:0] idle_coil(input int idx);
    return HOLD ? tbl[idx] : 4'b0000;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".coil"},       32'(bus.coil),       32'h0);
    check({tag, ".coil_en"},    32'(bus.coil_en),    32'h0);
    check({tag, ".busy"},       32'(bus.busy),       32'h0);
    check({tag, ".done"},       32'(bus.done),       32'h0);
    check({tag, ".steps_left"}, 32'(bus.steps_left), 32'h0);
    check({tag, ".position"},   32'(bus.position),   32'h0);
  endtask

  task automatic issue(input int n, input bit d, input bit h, input int p);
    bus.start     = 1'b1;
    bus.steps     = CNT_W'(n);
    bus.dir       = d;
    bus.half_step = h;
    bus.period    = DIV_W'(p);
    cyc();
    bus.start     = 1'b0;
  endtask

  initial begin
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    checks = 0;
    errors = 0;

    bus.motor_enable = 1'b1;
    bus.start        = 1'b0;
    bus.steps        = '0;
    bus.dir          = 1'b0;
    bus.half_step    = 1'b0;
    bus.period       = '0;
    bus.abort        = 1'b0;
    reset            = 1'b1;

    // Reset state.
    cyc();
    cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();
    check_all_zero("post_reset_idle");

    // Move 1: 4 full steps cw, period 3, from index 0.
    issue(4, 1'b0, 1'b0, 3);
    check("m1.accept.busy",       32'(bus.busy),       32'h1);
    check("m1.accept.steps_left", 32'(bus.steps_left), 32'd4);
    check("m1.accept.coil",       32'(bus.coil),       32'b1000);
    check("m1.accept.coil_en",    32'(bus.coil_en),    32'h1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("m1.coil",       32'(bus.coil),       32'(tbl[(2 * (k / 3)) % 8]));
      check("m1.steps_left", 32'(bus.steps_left), 32'(4 - k / 3));
      check("m1.position",   32'(bus.position),   32'(pos(k / 3)));
      check("m1.busy",       32'(bus.busy),       32'(k < 12));
      check("m1.done",       32'(bus.done),       32'(k == 12));
    end
    cyc();
    check("m1.after.done",    32'(bus.done),    32'h0);
    check("m1.after.coil",    32'(bus.coil),    32'(idle_coil(0)));
    check("m1.after.coil_en", 32'(bus.coil_en), 32'(HOLD));

    // Move 2 from a fresh reset: 3 half steps ccw, period 1.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    issue(3, 1'b1, 1'b1, 1);
    check("m2.accept.coil", 32'(bus.coil), 32'b1000);
    cyc();
    check("m2.s1.coil",     32'(bus.coil),     32'b1001);
    check("m2.s1.position", 32'(bus.position), 32'(pos(-1)));
    cyc();
    check("m2.s2.coil",     32'(bus.coil),     32'b0001);
    check("m2.s2.position", 32'(bus.position), 32'(pos(-2)));
    cyc();
    check("m2.s3.coil",       32'(bus.coil),       32'b0011);
    check("m2.s3.position",   32'(bus.position),   32'(pos(-3)));
    check("m2.s3.done",       32'(bus.done),       32'h1);
    check("m2.s3.busy",       32'(bus.busy),       32'h0);
    check("m2.s3.steps_left", 32'(bus.steps_left), 32'h0);

    // Zero-length move: done pulse only. Index is now 5.
    cyc();
    issue(0, 1'b0, 1'b0, 1);
    check("zero.done", 32'(bus.done), 32'h1);
    check("zero.busy", 32'(bus.busy), 32'h0);
    check("zero.coil", 32'(bus.coil), 32'(idle_coil(5)));
    cyc();
    check("zero.done_clear", 32'(bus.done), 32'h0);
    check("zero.busy_low",   32'(bus.busy), 32'h0);

    // Abort: 10 full steps cw, period 2, from index 5, abort after 3 steps.
    issue(10, 1'b0, 1'b0, 2);
    for (int k = 1; k <= 6; k++) cyc();
    check("ab.s3.steps_left", 32'(bus.steps_left), 32'd7);
    check("ab.s3.position",   32'(bus.position),   32'(pos(0)));
    check("ab.s3.coil",       32'(bus.coil),       32'b0110);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("ab.busy",       32'(bus.busy),       32'h0);
    check("ab.done",       32'(bus.done),       32'h0);
    check("ab.steps_left", 32'(bus.steps_left), 32'd7);
    check("ab.position",   32'(bus.position),   32'(pos(0)));
    check("ab.coil",       32'(bus.coil),       32'(idle_coil(3)));
    cyc();
    check("ab.no_done", 32'(bus.done), 32'h0);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("ab_idle.busy",       32'(bus.busy),       32'h0);
    check("ab_idle.steps_left", 32'(bus.steps_left), 32'd7);

    // Enable drop: 5 half steps cw, period 2, from index 3, position 0.
    issue(5, 1'b0, 1'b1, 2);
    cyc();
    cyc();
    check("en.s1.coil",       32'(bus.coil),       32'b0010);
    check("en.s1.steps_left", 32'(bus.steps_left), 32'd4);
    cyc();
    bus.motor_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("en.low.coil",       32'(bus.coil),       32'h0);
      check("en.low.coil_en",    32'(bus.coil_en),    32'h0);
      check("en.low.steps_left", 32'(bus.steps_left), 32'd4);
      check("en.low.position",   32'(bus.position),   32'(pos(1)));
      check("en.low.busy",       32'(bus.busy),       32'h1);
    end
    bus.motor_enable = 1'b1;
    cyc();
    check("en.s2.coil",       32'(bus.coil),       32'b0011);
    check("en.s2.steps_left", 32'(bus.steps_left), 32'd3);
    check("en.s2.position",   32'(bus.position),   32'(pos(2)));
    for (int s = 3; s <= 5; s++) begin
      cyc();
      cyc();
      check("en.coil",       32'(bus.coil),       32'(tbl[(3 + s) % 8]));
      check("en.steps_left", 32'(bus.steps_left), 32'(5 - s));
      check("en.position",   32'(bus.position),   32'(pos(s)));
      check("en.done",       32'(bus.done),       32'(s == 5));
    end
    cyc();
    check("en.idle.coil",    32'(bus.coil),    32'(idle_coil(0)));
    check("en.idle.coil_en", 32'(bus.coil_en), 32'(HOLD));
    bus.motor_enable = 1'b0;
    cyc();
    check("en.idle_off.coil_en", 32'(bus.coil_en), 32'h0);
    bus.motor_enable = 1'b1;

    // Reset mid-move clears outputs without a clock edge.
    issue(8, 1'b0, 1'b0, 3);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    cyc();
    reset = 1'b0;
    cyc();
    check_all_zero("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
